i2s_tx_serializer: RTL and testbench

Parametrised I2S / left-justified audio DAC transmitter for the WM8731 audio path. It generates BCLK and LRCK as registered outputs in the single system clock domain; no derived clocks are used. Stereo samples are accepted through a valid/ready handshake into a one-frame holding register, then shifted out MSB-first. Sample width, slot width, bit-clock rate and framing mode are configurable. The block reports underruns and finishes the current frame cleanly when disabled.

---
 rtl/i2s_tx_serializer_if.sv | 12 +
 rtl/i2s_tx_serializer.sv | 136 +++++++++++++
 tb/tb_i2s_tx_serializer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_serializer_if.sv
// Stereo sample handshake between an audio source and the I2S transmitter.
interface i2s_tx_serializer_if #(
  parameter int SAMPLE_W = 16
);
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_left;
  logic [SAMPLE_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S / left-justified DAC transmitter: BCLK/LRCK/DACDAT are registers in the clk domain.
// One-frame holding register; s_ready is low while a pair is held, freed at each frame load.
module i2s_tx_serializer #(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 32,
  parameter int BCLK_HALF = 4,
  parameter int I2S_MODE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  i2s_tx_serializer_if.slave   smp,
  output logic                 AUD_BCLK,
  output logic                 AUD_DACLRCK,
  output logic                 AUD_DACDAT,
  output logic                 frame_start,
  output logic                 underrun
);
  localparam int FW = 2 * SLOT_W;
  localparam int PW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BW = $clog2(FW);
  localparam logic LEFT_LVL = (I2S_MODE == 0);
  localparam logic IDLE_LVL = (I2S_MODE != 0);
  localparam logic [PW-1:0] P_LAST      = PW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] B_LAST      = BW'(FW - 1);
  localparam logic [BW-1:0] B_SLOT_LAST = BW'(SLOT_W - 1);

  generate
    if ((SLOT_W < SAMPLE_W + I2S_MODE) || (SAMPLE_W < 2) || (BCLK_HALF < 1)) begin : g_bad_params
      $error("i2s_tx_serializer: SLOT_W must be >= SAMPLE_W + I2S_MODE, SAMPLE_W >= 2, BCLK_HALF >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [BW-1:0]   bit_cnt;
  logic            hold_empty;
  pair_t           hold;
  logic [FW-1:0]   frame_sr;

  logic            tick;
  logic            fall;
  logic            frame_end;
  logic            load;
  logic            stop;
  logic [FW-1:0]   next_frame;

  // Slot image MSB-first; Philips mode pushes the sample one BCLK later.
  function automatic logic [SLOT_W-1:0] slot_of(input logic [SAMPLE_W-1:0] s);
    logic [SLOT_W-1:0] t;
    t = '0;
    t[SLOT_W-1 -: SAMPLE_W] = s;
    return t >> I2S_MODE;
  endfunction

  always_comb begin
    tick       = (state != IDLE) && (presc == P_LAST);
    fall       = tick && AUD_BCLK;
    frame_end  = fall && (bit_cnt == B_LAST);
    load       = ((state == IDLE) && enable) || (frame_end && ((state == RUN) || enable));
    stop       = frame_end && !load;
    next_frame = hold_empty ? '0 : {slot_of(hold.left), slot_of(hold.right)};
  end

  assign smp.s_ready = hold_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      presc       <= '0;
      bit_cnt     <= '0;
      hold_empty  <= 1'b1;
      hold        <= '0;
      frame_sr    <= '0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= IDLE_LVL;
      AUD_DACDAT  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (state == IDLE) begin
        if (enable) state <= RUN;
      end else if (stop) begin
        state <= IDLE;
      end else if (enable) begin
        state <= RUN;
      end else begin
        state <= DRAIN;
      end

      if (tick) begin
        presc    <= '0;
        AUD_BCLK <= ~AUD_BCLK;
      end else if (state != IDLE) begin
        presc <= presc + 1'b1;
      end

      // frame_sr holds the bits still to be shown after the current AUD_DACDAT.
      if (load) begin
        bit_cnt     <= '0;
        AUD_DACLRCK <= LEFT_LVL;
        AUD_DACDAT  <= next_frame[FW-1];
        frame_sr    <= next_frame << 1;
        frame_start <= 1'b1;
        underrun    <= hold_empty;
        hold_empty  <= 1'b1;
      end else if (stop) begin
        bit_cnt     <= '0;
        AUD_DACLRCK <= IDLE_LVL;
        AUD_DACDAT  <= 1'b0;
        frame_sr    <= '0;
      end else if (fall) begin
        bit_cnt     <= bit_cnt + 1'b1;
        AUD_DACLRCK <= (bit_cnt >= B_SLOT_LAST) ? ~LEFT_LVL : LEFT_LVL;
        AUD_DACDAT  <= frame_sr[FW-1];
        frame_sr    <= frame_sr << 1;
      end

      // Only possible while empty, so it never collides with the load freeing a full holder.
      if (smp.s_valid && hold_empty) begin
        hold       <= {smp.s_left, smp.s_right};
        hold_empty <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: Philips and left-justified framing, underrun, drain, reset.
module tb_i2s_tx_serializer;
  logic clk = 1'b0;
  logic rst;
  logic en, en_lj;
  logic bclk, lrck, dat, fs, ur;
  logic bclk_lj, lrck_lj, dat_lj, fs_lj, ur_lj;
  int   vectors = 0;
  int   miscompares = 0;
  int   feed_cnt;

  i2s_tx_serializer_if #(.SAMPLE_W(16)) bus ();
  i2s_tx_serializer_if #(.SAMPLE_W(16)) bus_lj ();

  i2s_tx_serializer #(.SAMPLE_W(16), .SLOT_W(32), .BCLK_HALF(2), .I2S_MODE(1)) dut (
    .clk(clk), .rst(rst), .enable(en), .smp(bus.slave),
    .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat),
    .frame_start(fs), .underrun(ur)
  );

  i2s_tx_serializer #(.SAMPLE_W(16), .SLOT_W(32), .BCLK_HALF(2), .I2S_MODE(0)) dut_lj (
    .clk(clk), .rst(rst), .enable(en_lj), .smp(bus_lj.slave),
    .AUD_BCLK(bclk_lj), .AUD_DACLRCK(lrck_lj), .AUD_DACDAT(dat_lj),
    .frame_start(fs_lj), .underrun(ur_lj)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit lj, input logic [15:0] l, input logic [15:0] r);
    int w;
    w = 0;
    if (lj) begin bus_lj.s_left = l; bus_lj.s_right = r; bus_lj.s_valid = 1'b1; end
    else    begin bus.s_left = l;    bus.s_right = r;    bus.s_valid = 1'b1;    end
    while (((lj ? bus_lj.s_ready : bus.s_ready) !== 1'b1) && w < 600) begin tick(); w++; end
    tick();
    if (lj) bus_lj.s_valid = 1'b0; else bus.s_valid = 1'b0;
    vectors++; if (w >= 600) begin miscompares++; $display("FAIL push_wait: waited %0d cycles, want < 600", w); end
    vectors++; if ((lj ? bus_lj.s_ready : bus.s_ready) !== 1'b0) begin miscompares++;
      $display("FAIL push_ready_drop: got %b want 0", lj ? bus_lj.s_ready : bus.s_ready); end
  endtask

  // Observes one 256-cycle frame after the load cycle; records data/LRCK at every BCLK rise.
  task automatic capture(input bit lj, input bit feed, input int dis_at, input int en_at,
                         output logic [63:0] dv, output logic [63:0] lv, output int rises,
                         output int first_rise, output int evt_mid, output int rdy_mid, output int acc);
    logic pb, b, rdy_pre;
    dv = '0; lv = '0; rises = 0; first_rise = -1; evt_mid = 0; rdy_mid = 0; acc = 0;
    pb = lj ? bclk_lj : bclk;
    for (int k = 1; k <= 256; k++) begin
      if (k - 1 == dis_at) begin if (lj) en_lj = 1'b0; else en = 1'b0; end
      if (k - 1 == en_at)  begin if (lj) en_lj = 1'b1; else en = 1'b1; end
      rdy_pre = lj ? bus_lj.s_ready : bus.s_ready;
      tick();
      if (feed && rdy_pre && bus.s_valid) begin
        feed_cnt++; acc++;
        bus.s_left  = 16'h1000 + 16'(feed_cnt);
        bus.s_right = 16'h2000 + 16'(feed_cnt);
      end
      b = lj ? bclk_lj : bclk;
      if (b && !pb) begin
        if (rises < 64) begin
          dv[63-rises] = lj ? dat_lj : dat;
          lv[63-rises] = lj ? lrck_lj : lrck;
        end
        if (first_rise < 0) first_rise = k;
        rises++;
      end
      pb = b;
      if (k < 256) begin
        if (lj ? (fs_lj | ur_lj) : (fs | ur)) evt_mid++;
        if (lj ? bus_lj.s_ready : bus.s_ready) rdy_mid++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++; if (bclk !== 1'b0) begin miscompares++; $display("FAIL reset_bclk: got %b want 0", bclk); end
    vectors++; if (lrck !== 1'b1) begin miscompares++; $display("FAIL reset_lrck_i2s: got %b want 1", lrck); end
    vectors++; if (lrck_lj !== 1'b0) begin miscompares++; $display("FAIL reset_lrck_lj: got %b want 0", lrck_lj); end
    vectors++; if (dat !== 1'b0) begin miscompares++; $display("FAIL reset_dat: got %b want 0", dat); end
    vectors++; if ({fs, ur} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b want 00", {fs, ur}); end
    vectors++; if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.s_ready); end
    rst = 1'b0;
    repeat (4) tick();
    vectors++; if ({bclk, lrck} !== 2'b01) begin miscompares++; $display("FAIL idle_hold: bclk,lrck got %b want 01", {bclk, lrck}); end
  endtask

  task automatic test_i2s_frame();
    logic [63:0] dv, lv;
    int rises, fr, evt, rdy, acc;
    push(1'b0, 16'hA5C3, 16'h8001);
    en = 1'b1;
    tick();
    vectors++; if ({fs, ur} !== 2'b10) begin miscompares++; $display("FAIL i2s_start_pulses: got %b want 10", {fs, ur}); end
    vectors++; if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL i2s_start_ready: got %b want 1", bus.s_ready); end
    vectors++; if ({bclk, lrck, dat} !== 3'b000) begin miscompares++; $display("FAIL i2s_start_lines: got %b want 000", {bclk, lrck, dat}); end
    capture(1'b0, 1'b0, -1, -1, dv, lv, rises, fr, evt, rdy, acc);
    vectors++; if (dv !== 64'h52E18000_40008000) begin miscompares++; $display("FAIL i2s_f1_data: got %h want 52e1800040008000", dv); end
    vectors++; if (lv !== 64'h00000000_FFFFFFFF) begin miscompares++; $display("FAIL i2s_f1_lrck: got %h want 00000000ffffffff", lv); end
    vectors++; if (rises !== 64) begin miscompares++; $display("FAIL i2s_f1_rises: got %0d want 64", rises); end
    vectors++; if (fr !== 2) begin miscompares++; $display("FAIL i2s_first_rise: got %0d want 2", fr); end
    vectors++; if (evt !== 0) begin miscompares++; $display("FAIL i2s_f1_mid_pulses: got %0d want 0", evt); end
    vectors++; if ({fs, ur, lrck} !== 3'b110) begin miscompares++; $display("FAIL i2s_f2_start: fs,ur,lrck got %b want 110", {fs, ur, lrck}); end
    capture(1'b0, 1'b0, -1, -1, dv, lv, rises, fr, evt, rdy, acc);
    vectors++; if (dv !== 64'h0) begin miscompares++; $display("FAIL i2s_f2_silence: got %h want 0", dv); end
    vectors++; if ({fs, ur} !== 2'b11) begin miscompares++; $display("FAIL i2s_f3_start: got %b want 11", {fs, ur}); end
    capture(1'b0, 1'b0, 0, -1, dv, lv, rises, fr, evt, rdy, acc);
    vectors++; if (dv !== 64'h0) begin miscompares++; $display("FAIL i2s_f3_silence: got %h want 0", dv); end
    vectors++; if ({fs, ur, bclk, lrck, dat} !== 5'b00010) begin miscompares++;
      $display("FAIL i2s_drain_idle: fs,ur,bclk,lrck,dat got %b want 00010", {fs, ur, bclk, lrck, dat}); end
  endtask

  task automatic test_left_justified();
    logic [63:0] dv, lv;
    int rises, fr, evt, rdy, acc;
    push(1'b1, 16'hA5C3, 16'h8001);
    en_lj = 1'b1;
    tick();
    vectors++; if ({fs_lj, ur_lj, lrck_lj, dat_lj} !== 4'b1011) begin miscompares++;
      $display("FAIL lj_start: fs,ur,lrck,dat got %b want 1011", {fs_lj, ur_lj, lrck_lj, dat_lj}); end
    capture(1'b1, 1'b0, 0, -1, dv, lv, rises, fr, evt, rdy, acc);
    vectors++; if (dv !== 64'hA5C30000_80010000) begin miscompares++; $display("FAIL lj_data: got %h want a5c3000080010000", dv); end
    vectors++; if (lv !== 64'hFFFFFFFF_00000000) begin miscompares++; $display("FAIL lj_lrck: got %h want ffffffff00000000", lv); end
    vectors++; if (rises !== 64) begin miscompares++; $display("FAIL lj_rises: got %0d want 64", rises); end
    vectors++; if ({fs_lj, bclk_lj, lrck_lj} !== 3'b000) begin miscompares++;
      $display("FAIL lj_idle: fs,bclk,lrck got %b want 000", {fs_lj, bclk_lj, lrck_lj}); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] dv, lv, exp;
    int rises, fr, evt, rdy, acc;
    feed_cnt = 0;
    bus.s_left = 16'h1000; bus.s_right = 16'h2000; bus.s_valid = 1'b1;
    tick();
    feed_cnt = 1;
    bus.s_left = 16'h1001; bus.s_right = 16'h2001;
    vectors++; if (bus.s_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_drop: got %b want 0", bus.s_ready); end
    en = 1'b1;
    tick();
    vectors++; if ({fs, ur, bus.s_ready} !== 3'b101) begin miscompares++;
      $display("FAIL b2b_start: fs,ur,ready got %b want 101", {fs, ur, bus.s_ready}); end
    for (int i = 0; i < 3; i++) begin
      capture(1'b0, 1'b1, -1, -1, dv, lv, rises, fr, evt, rdy, acc);
      exp = {1'b0, 16'h1000 + 16'(i), 15'h0, 1'b0, 16'h2000 + 16'(i), 15'h0};
      vectors++; if (dv !== exp) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, dv, exp); end
      vectors++; if (acc !== 1) begin miscompares++; $display("FAIL b2b_accepts[%0d]: got %0d want 1", i, acc); end
      vectors++; if (rdy !== 0) begin miscompares++; $display("FAIL b2b_ready_mid[%0d]: got %0d high cycles want 0", i, rdy); end
      vectors++; if ({fs, ur, bus.s_ready} !== 3'b101) begin miscompares++;
        $display("FAIL b2b_next[%0d]: fs,ur,ready got %b want 101", i, {fs, ur, bus.s_ready}); end
    end
    bus.s_valid = 1'b0;
    capture(1'b0, 1'b0, 0, -1, dv, lv, rises, fr, evt, rdy, acc);
    vectors++; if (dv !== 64'h08018000_10018000) begin miscompares++; $display("FAIL b2b_last: got %h want 0801800010018000", dv); end
    vectors++; if (feed_cnt !== 4) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", feed_cnt); end
    vectors++; if ({fs, bclk, lrck} !== 3'b001) begin miscompares++; $display("FAIL b2b_idle: got %b want 001", {fs, bclk, lrck}); end
  endtask

  task automatic test_drain();
    logic [63:0] dv, lv;
    int rises, fr, evt, rdy, acc;
    push(1'b0, 16'h1234, 16'hFEDC);
    en = 1'b1;
    tick();
    vectors++; if (fs !== 1'b1) begin miscompares++; $display("FAIL drain1_start: got %b want 1", fs); end
    capture(1'b0, 1'b0, 40, -1, dv, lv, rises, fr, evt, rdy, acc);
    vectors++; if (dv !== 64'h091A0000_7F6E0000) begin miscompares++; $display("FAIL drain1_data: got %h want 091a00007f6e0000", dv); end
    vectors++; if (rises !== 64) begin miscompares++; $display("FAIL drain1_rises: got %0d want 64", rises); end
    vectors++; if ({fs, ur, bclk, lrck, dat} !== 5'b00010) begin miscompares++;
      $display("FAIL drain1_idle: fs,ur,bclk,lrck,dat got %b want 00010", {fs, ur, bclk, lrck, dat}); end
    repeat (5) tick();
    vectors++; if ({fs, bclk} !== 2'b00) begin miscompares++; $display("FAIL drain1_stays_idle: got %b want 00", {fs, bclk}); end

    push(1'b0, 16'h0F0F, 16'hF0F0);
    en = 1'b1;
    tick();
    capture(1'b0, 1'b0, 40, 160, dv, lv, rises, fr, evt, rdy, acc);
    vectors++; if (dv !== 64'h07878000_78780000) begin miscompares++; $display("FAIL drain2_data: got %h want 0787800078780000", dv); end
    vectors++; if (evt !== 0) begin miscompares++; $display("FAIL drain2_extra_pulse: got %0d want 0", evt); end
    vectors++; if ({fs, ur, lrck} !== 3'b110) begin miscompares++; $display("FAIL drain2_continue: got %b want 110", {fs, ur, lrck}); end
  endtask

  task automatic test_mid_frame_reset();
    logic [63:0] dv, lv;
    int rises, fr, evt, rdy, acc;
    push(1'b0, 16'h5A5A, 16'h3C3C);
    repeat (81) tick();
    vectors++; if (bclk !== 1'b1) begin miscompares++; $display("FAIL pre_reset_bclk: got %b want 1", bclk); end
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    vectors++; if ({bclk, lrck, dat, fs, ur} !== 5'b01000) begin miscompares++;
      $display("FAIL rst_outputs: bclk,lrck,dat,fs,ur got %b want 01000", {bclk, lrck, dat, fs, ur}); end
    vectors++; if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", bus.s_ready); end
    repeat (4) tick();
    vectors++; if ({bclk, lrck} !== 2'b01) begin miscompares++; $display("FAIL rst_idle: got %b want 01", {bclk, lrck}); end
    push(1'b0, 16'hC001, 16'h7FFE);
    en = 1'b1;
    tick();
    vectors++; if ({fs, ur} !== 2'b10) begin miscompares++; $display("FAIL rst_restart: got %b want 10", {fs, ur}); end
    capture(1'b0, 1'b0, 0, -1, dv, lv, rises, fr, evt, rdy, acc);
    vectors++; if (dv !== 64'h60008000_3FFF0000) begin miscompares++; $display("FAIL rst_clean_data: got %h want 600080003fff0000", dv); end
    vectors++; if (fr !== 2) begin miscompares++; $display("FAIL rst_first_rise: got %0d want 2", fr); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en_lj = 1'b0; feed_cnt = 0;
    bus.s_valid = 1'b0;    bus.s_left = '0;    bus.s_right = '0;
    bus_lj.s_valid = 1'b0; bus_lj.s_left = '0; bus_lj.s_right = '0;
    test_reset();
    test_i2s_frame();
    test_left_justified();
    test_back_to_back();
    test_drain();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
